seven_segment_reader: RTL
=========================

// Module: seven_segment_reader
// PURPOSE
//  Receive-side decoder for the frequency counter's multiplexed two-digit seven-segment output.
//  Watches segments[6:0] and the digit-select line, accepts a pattern once it is stable, and maps it back to BCD.
//  Pairs one tens and one units capture into a frame and presents the frame as BCD and binary.
//  Used as a loopback checker on spare user-project logic and as the display monitor in chip-level benches.
// PARAMETERS
//  SETTLE_CYCLES  4    consecutive identical synced samples required before capture (>=1)
//  TIMEOUT        4096 cycles without a digit-line change before stalled asserts (must be > SETTLE_CYCLES+2)
// PORTS
//  clk          in   1  system clock
//  reset        in   1  synchronous, active-high reset
//  segments     in   7  segment lines, active-high, [0]=a .. [6]=g
//  digit        in   1  display select: 0 = units digit shown, 1 = tens digit shown
//  tens         out  4  BCD tens of last good frame
//  units        out  4  BCD units of last good frame
//  value        out  7  tens*10+units, binary, 0..99
//  valid        out  1  one-cycle pulse: new frame on tens/units/value
//  err          out  1  one-cycle pulse: captured pattern not in the decode table
//  stalled      out  1  level: digit line idle for TIMEOUT cycles
//  frame_count  out  8  number of valid pulses since reset, wraps 255->0
// BEHAVIOUR
//  Interface: one clock (clk); reset is synchronous and active-high (reset).
//  Reset: all outputs 0; sync flops, stable counter, watchdog, have_tens/have_units, captured flag cleared.
//  Sync: segments and digit pass through a 2-flop synchronizer; s_seg/s_digit lag the pins by 2 clocks.
//  Stability: stable_cnt increments (saturating at SETTLE_CYCLES) when {s_seg,s_digit} equals the previous cycle's value, else 0.
//  Capture: on the first edge where stable_cnt reaches SETTLE_CYCLES-1 while captured==0; then captured=1.
//  captured clears only when s_digit changes -> exactly one capture per digit phase; a segment glitch inside a phase does not re-capture.
//  Decode: 3F=0 06=1 5B=2 4F=3 66=4 6D=5 7D=6 07=7 7F=8 6F=9; 00 (blank) = 0, so a blanked tens digit reads 0.
//  Good capture: write into the tens or units holding reg according to s_digit and set the matching have_ flag.
//    If both have_ flags are then set, the next cycle registers tens/units/value, pulses valid, increments frame_count,
//    and clears both flags.
//  Capture order: either order (tens then units, or units then tens) forms a frame.
//  Same digit captured twice without the other: the second capture overwrites the holding reg; no frame.
//  Bad capture: err pulses 1 cycle later; both have_ flags cleared (partial frame dropped); outputs keep the last good frame.
//  Latency: pins stable at edge k -> capture at edge k+2+SETTLE_CYCLES-1 -> valid high during the following cycle.
//  Watchdog: idle_cnt resets on any s_digit change and otherwise increments, saturating.
//    At TIMEOUT: stalled=1 and both have_ flags clear; stalled drops on the cycle after the next s_digit change.
//  Priority in one cycle: reset > capture > watchdog clear. valid and err never assert together.
//  Width: value computed as {tens,3'b0}+{tens,1'b0}+units, 7 bits; no overflow since inputs are 0..9.
//  Reset mid-frame: partial frame discarded; the first frame after reset needs fresh captures of both digits.
// TESTING
//  1 digit=1 seg=4F for 20 clk, then digit=0 seg=6D for 20 clk -> one valid; tens=3 units=5 value=35 frame_count=1.
//  2 Reverse order (units 7F, then tens 06) -> valid with value=18; check valid lands exactly 1+2+SETTLE_CYCLES after the second pattern is applied.
//  3 Glitch: units pattern held 2 clk then changed (SETTLE_CYCLES=4) -> no capture; stable 4+ clk -> capture.
//  4 tens seg=0x12 (invalid) -> err 1-cycle pulse, no valid; the next good tens+units pair -> valid with the new values.
//  5 Hold digit constant 4096 clk -> stalled=1; toggle digit -> stalled=0; the next full pair -> valid.
//  6 Assert reset after the tens capture, then units only -> no valid; all outputs read 0 during/after reset.

Source files
------------

// File: rtl/seven_segment_reader.sv
// rtl/seven_segment_reader.sv - decodes a multiplexed two-digit seven-segment display back into BCD and binary frames
module seven_segment_reader #(
  parameter int SETTLE_CYCLES = 4,
  parameter int TIMEOUT       = 4096
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] segments,
  input  logic       digit,
  output logic [3:0] tens,
  output logic [3:0] units,
  output logic [6:0] value,
  output logic       valid,
  output logic       err,
  output logic       stalled,
  output logic [7:0] frame_count
);

  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam int IW = $clog2(TIMEOUT + 1);

  logic [6:0]    seg_meta, s_seg, p_seg;
  logic          dig_meta, s_digit, p_digit;
  logic [CW-1:0] stable_cnt, stable_next;
  logic          captured;
  logic          digit_changed;
  logic          capture;
  logic [IW-1:0] idle_cnt, idle_next;
  logic          timeout_hit;
  logic          have_tens, have_units;
  logic [3:0]    hold_tens, hold_units;
  logic          err_pend;
  logic [3:0]    dec_val;
  logic          dec_ok;

  // Two-flop synchronizer on the display lines; the display is driven from another domain.
  always_ff @(posedge clk) begin
    if (reset) begin
      seg_meta <= 7'd0;
      s_seg    <= 7'd0;
      dig_meta <= 1'b0;
      s_digit  <= 1'b0;
    end else begin
      seg_meta <= segments;
      s_seg    <= seg_meta;
      dig_meta <= digit;
      s_digit  <= dig_meta;
    end
  end

  // Stability counter, digit-change detect, capture strobe and watchdog next-state.
  always_comb begin
    digit_changed = (s_digit != p_digit);
    stable_next   = '0;
    if ({s_seg, s_digit} == {p_seg, p_digit}) begin
      if (stable_cnt == CW'(SETTLE_CYCLES)) begin
        stable_next = stable_cnt;
      end else begin
        stable_next = stable_cnt + CW'(1);
      end
    end
    // A digit change re-arms capture in the same cycle so SETTLE_CYCLES=1 still works.
    capture = (!captured || digit_changed) && (stable_next == CW'(SETTLE_CYCLES - 1));
    idle_next = '0;
    if (!digit_changed) begin
      if (idle_cnt == IW'(TIMEOUT)) begin
        idle_next = idle_cnt;
      end else begin
        idle_next = idle_cnt + IW'(1);
      end
    end
    timeout_hit = (idle_next == IW'(TIMEOUT));
  end

  // Segment pattern to BCD; a blank digit reads as zero so a suppressed leading tens decodes.
  always_comb begin
    dec_val = 4'd0;
    dec_ok  = 1'b1;
    case (s_seg)
      7'h3F: dec_val = 4'd0;
      7'h06: dec_val = 4'd1;
      7'h5B: dec_val = 4'd2;
      7'h4F: dec_val = 4'd3;
      7'h66: dec_val = 4'd4;
      7'h6D: dec_val = 4'd5;
      7'h7D: dec_val = 4'd6;
      7'h07: dec_val = 4'd7;
      7'h7F: dec_val = 4'd8;
      7'h6F: dec_val = 4'd9;
      7'h00: dec_val = 4'd0;
      default: dec_ok = 1'b0;
    endcase
  end

  // Previous synced sample, stability count and one-capture-per-phase flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      p_seg      <= 7'd0;
      p_digit    <= 1'b0;
      stable_cnt <= '0;
      captured   <= 1'b0;
    end else begin
      p_seg      <= s_seg;
      p_digit    <= s_digit;
      stable_cnt <= stable_next;
      if (capture) begin
        captured <= 1'b1;
      end else if (digit_changed) begin
        captured <= 1'b0;
      end
    end
  end

  // Digit-line watchdog; stalled follows the saturated idle count.
  always_ff @(posedge clk) begin
    if (reset) begin
      idle_cnt <= '0;
      stalled  <= 1'b0;
    end else begin
      idle_cnt <= idle_next;
      stalled  <= timeout_hit;
    end
  end

  // Holding registers, frame assembly and output pulses; later assignments take priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      have_tens   <= 1'b0;
      have_units  <= 1'b0;
      hold_tens   <= 4'd0;
      hold_units  <= 4'd0;
      tens        <= 4'd0;
      units       <= 4'd0;
      value       <= 7'd0;
      valid       <= 1'b0;
      err         <= 1'b0;
      err_pend    <= 1'b0;
      frame_count <= 8'd0;
    end else begin
      valid    <= 1'b0;
      err      <= err_pend;
      err_pend <= 1'b0;
      if (have_tens && have_units) begin
        tens        <= hold_tens;
        units       <= hold_units;
        value       <= {hold_tens, 3'b000} + {2'b00, hold_tens, 1'b0} + {3'b000, hold_units};
        valid       <= 1'b1;
        frame_count <= frame_count + 8'd1;
        have_tens   <= 1'b0;
        have_units  <= 1'b0;
      end
      if (timeout_hit && !capture) begin
        have_tens  <= 1'b0;
        have_units <= 1'b0;
      end
      if (capture) begin
        if (!dec_ok) begin
          err_pend   <= 1'b1;
          have_tens  <= 1'b0;
          have_units <= 1'b0;
        end else if (s_digit) begin
          hold_tens <= dec_val;
          have_tens <= 1'b1;
        end else begin
          hold_units <= dec_val;
          have_units <= 1'b1;
        end
      end
    end
  end

endmodule
